// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC constants and flit/request types.
package noc_pkg;
  localparam int NOC_DATA_W = 16;
  localparam int NOC_NUM_PORTS = 5;
  localparam int NOC_ADDR_W = 3;
  localparam int NOC_ADDR_LSB = 13;
  typedef logic [NOC_DATA_W-1:0] flit_t;
  typedef logic [NOC_NUM_PORTS-1:0] port_req_t;
endpackage

// File: rtl/noc_queue_ram.sv
// noc_queue_ram: DEPTH x DATA_W storage, synchronous write, asynchronous read.
module noc_queue_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 8
)(
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/noc_input_queue.sv
// noc_input_queue: per-port NoC input FIFO with head destination decode.
// Define NOC_QUEUE_BYPASS_EN for zero-latency bypass of an empty queue.
module noc_input_queue
  import noc_pkg::*;
#(
  parameter int DATA_W = NOC_DATA_W,
  parameter int DEPTH = 8,
  parameter int NUM_PORTS = NOC_NUM_PORTS,
  parameter int ADDR_W = NOC_ADDR_W,
  parameter int ADDR_LSB = NOC_ADDR_LSB
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_i,
  input  logic [DATA_W-1:0]          data_i,
  input  logic                       pop_req_i,
  output logic [DATA_W-1:0]          data_o,
  output logic                       en_o,
  output logic [NUM_PORTS-1:0]       req_port_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       overflow_o,
  output logic                       drop_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [ADDR_W:0] NP = (ADDR_W+1)'(NUM_PORTS);
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic full_q, full_d, ovf_q, ovf_d, drop_q, drop_d;
  logic [DATA_W-1:0] head;
  logic [ADDR_W-1:0] hdest;
  logic nonempty, hlegal, discard, pop_fire, push_ok, we, rd_inc, byp_pop;
  noc_queue_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk(clk), .we_i(we), .waddr_i(wr_q), .wdata_i(data_i), .raddr_i(rd_q), .rdata_o(head)
  );
  assign hdest = head[ADDR_LSB +: ADDR_W];
  assign nonempty = cnt_q != '0;
  assign hlegal = nonempty && ({1'b0, hdest} < NP);
  assign discard = nonempty && !hlegal;
`ifdef NOC_QUEUE_BYPASS_EN
  logic [ADDR_W-1:0] idest;
  logic byp;
  assign idest = data_i[ADDR_LSB +: ADDR_W];
  assign byp = !nonempty && valid_i && ({1'b0, idest} < NP);
  assign en_o = hlegal || byp;
  assign data_o = nonempty ? head : byp ? data_i : '0;
  assign req_port_o = en_o ? (NUM_PORTS'(1) << (byp ? idest : hdest)) : '0;
  assign byp_pop = byp && pop_req_i;
`else
  assign en_o = hlegal;
  assign data_o = nonempty ? head : '0;
  assign req_port_o = hlegal ? (NUM_PORTS'(1) << hdest) : '0;
  assign byp_pop = 1'b0;
`endif
  // A bypassed flit that is granted the same cycle never touches storage.
  assign pop_fire = pop_req_i && en_o;
  assign rd_inc = (pop_fire && !byp_pop) || discard;
  assign push_ok = valid_i && (cnt_q != FULL || rd_inc);
  assign we = push_ok && !byp_pop && rst;
  always_comb begin
    rd_d = rd_q + PW'(rd_inc);
    wr_d = wr_q + PW'(we);
    cnt_d = cnt_q + CW'(we) - CW'(rd_inc);
    full_d = cnt_d == FULL;
    ovf_d = ovf_q || (valid_i && !push_ok);
    drop_d = discard;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      full_q <= 1'b0;
      ovf_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      full_q <= full_d;
      ovf_q <= ovf_d;
      drop_q <= drop_d;
    end
  end
  assign count_o = cnt_q;
  assign full_o = full_q;
  assign overflow_o = ovf_q;
  assign drop_o = drop_q;
endmodule

// File: tb/tb_noc_input_queue.sv
// tb_noc_input_queue: directed self-checking bench for noc_input_queue.
module tb_noc_input_queue;
  logic clk = 1'b0, rst = 1'b0, valid_i = 1'b0, pop_req_i = 1'b0;
  logic [15:0] data_i = '0, data_o;
  logic en_o, full_o, overflow_o, drop_o;
  logic [4:0] req_port_o;
  logic [3:0] count_o;
  int tests = 0, fails = 0;
  logic [15:0] exp_q [8];
  noc_input_queue dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .data_i(data_i), .pop_req_i(pop_req_i),
    .data_o(data_o), .en_o(en_o), .req_port_o(req_port_o), .count_o(count_o),
    .full_o(full_o), .overflow_o(overflow_o), .drop_o(drop_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic v, input logic [15:0] d, input logic p);
    valid_i = v;
    data_i = d;
    pop_req_i = p;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    data_i = '0;
    pop_req_i = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    rst = 1'b1;
  endtask
  initial begin
    do_reset();
    chk("rst_count", count_o, 0);
    chk("rst_en", en_o, 0);
    chk("rst_req", req_port_o, 0);
    chk("rst_full", full_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_drop", drop_o, 0);
    chk("rst_data", data_o, 0);
    // single flit, 1-cycle latency, then pop
    cyc(1, 16'h2ABC, 0);
    chk("p1_en", en_o, 1);
    chk("p1_req", req_port_o, 5'b00010);
    chk("p1_data", data_o, 16'h2ABC);
    chk("p1_count", count_o, 1);
    cyc(0, 0, 1);
    chk("pop1_en", en_o, 0);
    chk("pop1_count", count_o, 0);
    chk("pop1_data", data_o, 0);
    // fill with dest cycling 0..4; write pointer wraps past DEPTH-1
    for (int i = 0; i < 8; i++) begin
      exp_q[i] = 16'((i % 5) << 13) | 16'(i + 1);
      cyc(1, exp_q[i], 0);
    end
    chk("fill_full", full_o, 1);
    chk("fill_count", count_o, 8);
    chk("fill_data", data_o, 16'h0001);
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", data_o, exp_q[i]);
      chk("drain_req", req_port_o, 32'(1) << (i % 5));
      chk("drain_en", en_o, 1);
      cyc(0, 0, 1);
    end
    chk("drain_count", count_o, 0);
    chk("drain_en_end", en_o, 0);
    chk("drain_full", full_o, 0);
    // second fill, then push+pop while full, then overflow
    for (int i = 0; i < 8; i++) begin
      exp_q[i] = 16'((i % 5) << 13) | 16'(i + 16);
      cyc(1, exp_q[i], 0);
    end
    chk("fill2_count", count_o, 8);
    chk("fill2_data", data_o, 16'h0010);
    cyc(1, 16'h6099, 1);
    chk("fullpp_count", count_o, 8);
    chk("fullpp_full", full_o, 1);
    chk("fullpp_ovf", overflow_o, 0);
    chk("fullpp_data", data_o, 16'h2011);
    cyc(1, 16'h0123, 0);
    chk("ovf_set", overflow_o, 1);
    chk("ovf_count", count_o, 8);
    chk("ovf_data", data_o, 16'h2011);
    exp_q[0] = 16'h6099;
    for (int i = 1; i < 8; i++) begin
      chk("drain2_data", data_o, exp_q[i]);
      cyc(0, 0, 1);
    end
    chk("drain2_last", data_o, 16'h6099);
    cyc(0, 0, 1);
    chk("drain2_count", count_o, 0);
    chk("ovf_sticky", overflow_o, 1);
    do_reset();
    chk("ovf_clear", overflow_o, 0);
    // illegal destination head is discarded
    cyc(1, 16'hE000, 0);
    chk("ill_en", en_o, 0);
    chk("ill_req", req_port_o, 0);
    chk("ill_data", data_o, 16'hE000);
    chk("ill_drop0", drop_o, 0);
    cyc(1, 16'h6000, 0);
    chk("ill_drop", drop_o, 1);
    chk("ill_count", count_o, 1);
    chk("ill_next_en", en_o, 1);
    chk("ill_next_req", req_port_o, 5'b01000);
    chk("ill_next_data", data_o, 16'h6000);
    cyc(0, 0, 0);
    chk("ill_drop_once", drop_o, 0);
    chk("ill_hold_data", data_o, 16'h6000);
    cyc(0, 0, 1);
    chk("ill_pop_count", count_o, 0);
    // pop on empty
    cyc(0, 0, 1);
    chk("emp_count", count_o, 0);
    chk("emp_en", en_o, 0);
    chk("emp_drop", drop_o, 0);
    chk("emp_ovf", overflow_o, 0);
    // reset with count 5 and a push pending
    for (int i = 0; i < 5; i++) cyc(1, 16'h2000 | 16'(i), 0);
    chk("pre_rst_count", count_o, 5);
    rst = 1'b0;
    cyc(1, 16'h0555, 0);
    rst = 1'b1;
    chk("mid_rst_count", count_o, 0);
    chk("mid_rst_en", en_o, 0);
    chk("mid_rst_data", data_o, 0);
    cyc(0, 0, 0);
    chk("post_rst_count", count_o, 0);
    cyc(1, 16'h4444, 0);
    chk("post_rst_data", data_o, 16'h4444);
    chk("post_rst_cnt1", count_o, 1);
    cyc(0, 0, 1);
    // empty queue, push and pop in the same cycle
    valid_i = 1'b1;
    data_i = 16'h8000;
    pop_req_i = 1'b1;
    #1;
`ifdef NOC_QUEUE_BYPASS_EN
    chk("byp_en", en_o, 1);
    chk("byp_req", req_port_o, 5'b10000);
    chk("byp_data", data_o, 16'h8000);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    pop_req_i = 1'b0;
    chk("byp_count", count_o, 0);
    chk("byp_en_after", en_o, 0);
`else
    chk("nobyp_en", en_o, 0);
    chk("nobyp_req", req_port_o, 0);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    pop_req_i = 1'b0;
    chk("nobyp_count", count_o, 1);
    chk("nobyp_req_next", req_port_o, 5'b10000);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
